div_unit: RTL and testbench

// Iterative RV32M divider for DIV, DIVU, REM and REMU. It works beside the single-cycle ALU in the execute stage.
// A restoring shift-subtract datapath produces one quotient bit per cycle.
// It exposes a start/busy/valid handshake so the hazard unit can stall the pipeline while it runs.

---
 rtl/div_unit.sv | 116 +++++++++++
 tb/tb_div_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU), restoring shift-subtract, one quotient bit per cycle
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [1:0]      op_q, op_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;

    logic            sgn, a_neg, b_neg, ovf;
    logic [XLEN-1:0] a_abs, b_abs, fast_res;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] quot_n, rem_n, q_fin, r_fin;

    // Operand conditioning, one restoring step, and next-state / datapath selection
    always_comb begin
        sgn      = ~op_i[0];
        a_neg    = sgn & src_a_i[XLEN-1];
        b_neg    = sgn & src_b_i[XLEN-1];
        a_abs    = a_neg ? -src_a_i : src_a_i;
        b_abs    = b_neg ? -src_b_i : src_b_i;
        ovf      = sgn && (src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b_i);
        fast_res = (src_b_i == '0) ? (op_i[1] ? src_a_i : '1) : (op_i[1] ? '0 : src_a_i);
        rem_sh   = {rem_q, quot_q[XLEN-1]};
        diff     = rem_sh - {1'b0, div_q};
        rem_n    = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        quot_n   = {quot_q[XLEN-2:0], ~diff[XLEN]};
        q_fin    = negq_q ? -quot_n : quot_n;
        r_fin    = negr_q ? -rem_n : rem_n;
        state_d  = state_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        div_d    = div_q;
        result_d = result_q;
        op_d     = op_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (start_i && state_q != RUN) begin
            op_d   = op_i;
            quot_d = a_abs;
            rem_d  = '0;
            div_d  = b_abs;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
            cnt_d  = CW'(XLEN);
            if (src_b_i == '0 || ovf) begin
                state_d  = DONE;
                result_d = fast_res;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            quot_d = quot_n;
            rem_d  = rem_n;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_d  = DONE;
                result_d = op_q[1] ? r_fin : q_fin;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            result_q <= result_d;
            op_q     <= op_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
        end
    end

    assign busy_o   = (state_q == RUN);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, valid_o;
    logic [31:0] result_o;
    int          errors = 0;
    int          checks = 0;

    div_unit #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int lat, nb;
        lat = 0;
        nb  = 0;
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            nb += int'(busy_o);
            if (valid_o) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result_o, exp);
        check({tag, " busy cycles"}, nb, exp_lat - 1);
    endtask

    task automatic no_valid(input string tag);
        int nv;
        nv = 0;
        repeat (40) begin
            @(negedge clk_i);
            nv += int'(valid_o);
        end
        check(tag, nv, 0);
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset busy", {31'b0, busy_o}, 32'd0);
        check("reset valid", {31'b0, valid_o}, 32'd0);
        check("reset result", result_o, 32'd0);
        rst_i = 1'b0;

        run_op("DIV 100/7",      2'b00, 32'd100,      32'd7,        32'd14,       33);
        run_op("REM 100/7",      2'b10, 32'd100,      32'd7,        32'd2,        33);
        run_op("DIV -7/2",       2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("REM -7/2",       2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("DIV 7/-2",       2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("REM 7/-2",       2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
        run_op("DIVU 8000/FFFF", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
        run_op("REMU 8000/FFFF", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        run_op("DIVU 5/0",       2'b01, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("REMU 5/0",       2'b11, 32'd5,        32'd0,        32'd5,        1);
        run_op("REM -5/0",       2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1);
        run_op("DIV overflow",   2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM overflow",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
        run_op("DIVU FFFF/2",    2'b01, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33);

        // flush at cycle 10 of a DIV
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd100; src_b_i = 32'd7;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("flush pre busy", {31'b0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush busy", {31'b0, busy_o}, 32'd0);
        check("flush valid", {31'b0, valid_o}, 32'd0);
        check("flush result held", result_o, 32'h7FFFFFFF);
        no_valid("flush no valid");
        run_op("DIVU 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // flush in the DONE cycle drops a simultaneous start
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b01; src_a_i = 32'd5; src_b_i = 32'd0;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        check("done flush valid seen", {31'b0, valid_o}, 32'd1);
        flush_i = 1'b1; start_i = 1'b1; op_i = 2'b01; src_a_i = 32'd9; src_b_i = 32'd3;
        @(negedge clk_i);
        flush_i = 1'b0; start_i = 1'b0;
        check("done flush busy", {31'b0, busy_o}, 32'd0);
        check("done flush valid", {31'b0, valid_o}, 32'd0);
        check("done flush result", result_o, 32'hFFFFFFFF);
        no_valid("done flush no valid");

        // reset mid-operation
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd100; src_b_i = 32'd7;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst busy", {31'b0, busy_o}, 32'd0);
        check("midrst valid", {31'b0, valid_o}, 32'd0);
        check("midrst result", result_o, 32'd0);
        rst_i = 1'b0;
        no_valid("midrst no valid");

        // back-to-back: start held high, operands change while busy
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd100; src_b_i = 32'd7;
        @(posedge clk_i);
        #1 op_i = 2'b01; src_a_i = 32'd9; src_b_i = 32'd3;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (valid_o) begin
                lat = k;
                break;
            end
        end
        check("b2b first latency", lat, 33);
        check("b2b first result", result_o, 32'd14);
        @(negedge clk_i);
        start_i = 1'b0;
        check("b2b second accepted", {31'b0, busy_o}, 32'd1);
        lat = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk_i);
            if (valid_o) begin
                lat = k;
                break;
            end
        end
        check("b2b second latency", lat, 33);
        check("b2b second result", result_o, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
